// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history/target table for the IF stage.
// Combinational 0-cycle lookup; trained by resolved branches from ID.
module branch_predictor_bht #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [XLEN-1:0]   lookup_pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [XLEN-1:0]   pred_target_o,
    input  logic              upd_valid_i,
    input  logic [XLEN-1:0]   upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [XLEN-1:0]   upd_target_i,
    input  logic              upd_mispred_i,
    input  logic              flush_i,
    output logic [STAT_W-1:0] mispred_cnt_o
);

    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int TAG_LSB = IDX_W + 2;
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_W'(1);

    logic [ENTRIES-1:0] valid_vec;
    logic [TAG_W-1:0]   tag_arr [ENTRIES];
    logic [CTR_W-1:0]   ctr_arr [ENTRIES];
    logic [XLEN-1:0]    tgt_arr [ENTRIES];

    logic [IDX_W-1:0]   lookup_idx;
    logic [TAG_W-1:0]   lookup_tag;
    logic [IDX_W-1:0]   upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic               upd_hit;
    logic [STAT_W-1:0]  mispred_cnt_reg;
    logic               unused_upd_pc;

    assign lookup_idx = lookup_pc_i[2 +: IDX_W];
    assign lookup_tag = lookup_pc_i[TAG_LSB +: TAG_W];
    assign upd_idx    = upd_pc_i[2 +: IDX_W];
    assign upd_tag    = upd_pc_i[TAG_LSB +: TAG_W];
    assign upd_hit    = valid_vec[upd_idx] && (tag_arr[upd_idx] == upd_tag);
    assign unused_upd_pc = ^upd_pc_i;

    // Lookup sees only registered state, so a same-cycle update is visible next cycle.
    assign pred_hit_o    = valid_vec[lookup_idx] && (tag_arr[lookup_idx] == lookup_tag);
    assign pred_taken_o  = pred_hit_o && ctr_arr[lookup_idx][CTR_W-1];
    assign pred_target_o = pred_taken_o ? tgt_arr[lookup_idx] : lookup_pc_i + XLEN'(4);

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             valid_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [CTR_W-1:0] ctr_reg;
            logic [XLEN-1:0]  tgt_reg;
            logic             sel;

            assign sel = upd_valid_i && (upd_idx == IDX_W'(gi));

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    valid_reg <= 1'b0;
                    tag_reg   <= '0;
                    ctr_reg   <= CTR_WEAK_NT;
                    tgt_reg   <= '0;
                end else if (flush_i) begin
                    valid_reg <= 1'b0;
                    ctr_reg   <= CTR_WEAK_NT;
                end else if (sel) begin
                    if (upd_hit) begin
                        if (upd_taken_i) begin
                            ctr_reg <= (&ctr_reg) ? ctr_reg : ctr_reg + CTR_W'(1);
                            tgt_reg <= upd_target_i;
                        end else begin
                            ctr_reg <= (|ctr_reg) ? ctr_reg - CTR_W'(1) : ctr_reg;
                        end
                    end else if (upd_taken_i) begin
                        // Not-taken misses never allocate, keeping the table for taken branches.
                        valid_reg <= 1'b1;
                        tag_reg   <= upd_tag;
                        ctr_reg   <= CTR_WEAK_T;
                        tgt_reg   <= upd_target_i;
                    end
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign tag_arr[gi]   = tag_reg;
            assign ctr_arr[gi]   = ctr_reg;
            assign tgt_arr[gi]   = tgt_reg;
        end
    endgenerate

    // Statistics survive a flush; a mispredict reported in the flush cycle still counts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mispred_cnt_reg <= '0;
        end else if (upd_valid_i && upd_mispred_i && !(&mispred_cnt_reg)) begin
            mispred_cnt_reg <= mispred_cnt_reg + STAT_W'(1);
        end
    end

    assign mispred_cnt_o = mispred_cnt_reg;

endmodule
